// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display controller.
// Holds segment encodings (active-low {a,b,c,d,e,f,g}), the converter FSM states
// and a sizing helper that counts the decimal digits needed for a binary width.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } dd_state_t;

  // Active-low segment pattern for one BCD digit; non-decimal codes go dark.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Number of decimal digits needed to hold 2^w-1.
  function automatic int bcd_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ssd_display_ctrl_if.sv
// Bus between the debug-select mux and the display controller.
// Ports: value/is_signed/load in (load is a one-cycle strobe), busy/overflow status out,
// Anode (active-low digit enables, bit 0 rightmost) and LED_out (active-low segments) out.
interface ssd_display_ctrl_if #(
  parameter int DATA_W = 13,
  parameter int DIGITS = 4
);
  logic [DATA_W-1:0] value;
  logic              is_signed;
  logic              load;
  logic              busy;
  logic              overflow;
  logic [DIGITS-1:0] Anode;
  logic [6:0]        LED_out;

  modport master (
    output value, is_signed, load,
    input  busy, overflow, Anode, LED_out
  );

  modport slave (
    input  value, is_signed, load,
    output busy, overflow, Anode, LED_out
  );
endinterface

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with sign capture.
// Latency: start accepted in IDLE or COMMIT, DATA_W SHIFT cycles, then one COMMIT cycle (done).
// Ports: clk/reset, start+value+is_signed in; ready, busy, done, bcd (valid while done), sign out.
module bcd_double_dabble
  import ssd_pkg::*;
#(
  parameter int DATA_W = 13,
  parameter int NDIG   = bcd_digits(DATA_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   value,
  input  logic                is_signed,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd,
  output logic                sign
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  dd_state_t         state, state_nxt;
  logic [DATA_W-1:0] mag, mag_nxt;
  logic [4*NDIG-1:0] bcd_q, bcd_nxt, adj;
  logic              sign_q, sign_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mag    <= '0;
      bcd_q  <= '0;
      sign_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      mag    <= mag_nxt;
      bcd_q  <= bcd_nxt;
      sign_q <= sign_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mag_nxt   = mag;
    bcd_nxt   = bcd_q;
    sign_nxt  = sign_q;
    cnt_nxt   = cnt;
    adj       = bcd_q;
    case (state)
      // COMMIT can chain straight into the next conversion so busy never drops.
      IDLE, COMMIT: begin
        if (start) begin
          sign_nxt  = is_signed & value[DATA_W-1];
          // Unsigned view of the negated value: the most negative input maps
          // to 2^(DATA_W-1) without wrapping.
          mag_nxt   = sign_nxt ? (~value + DATA_W'(1)) : value;
          bcd_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        for (int i = 0; i < NDIG; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_nxt = {adj[4*NDIG-2:0], mag[DATA_W-1]};
        mag_nxt = mag << 1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1))
          state_nxt = COMMIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state != SHIFT);
  assign busy  = (state != IDLE);
  assign done  = (state == COMMIT);
  assign bcd   = bcd_q;
  assign sign  = sign_q;

endmodule

// File: rtl/ssd_display_ctrl.sv
// Binary value to multiplexed N-digit seven-segment display with blanking, sign and overflow.
// Latency: busy for DATA_W+1 cycles per conversion; a load while busy is held (newest wins).
// Ports: clk, reset (async, active-high), bus (slave modport: value/load in, status and pins out).
module ssd_display_ctrl
  import ssd_pkg::*;
#(
  parameter int DATA_W      = 13,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_EN    = 1
) (
  input  logic               clk,
  input  logic               reset,
  ssd_display_ctrl_if.slave  bus
);

  localparam int NDIG  = bcd_digits(DATA_W);
  localparam int EXT   = (NDIG > DIGITS) ? NDIG : DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  // Converter hookup and one-deep pending load.
  logic              dd_ready, dd_busy, dd_done, dd_sign, start;
  logic [4*NDIG-1:0] dd_bcd;
  logic [DATA_W-1:0] pend_value, conv_value;
  logic              pend_signed, pend_vld, conv_signed;

  // A live load beats an older pending one.
  assign start       = dd_ready & (bus.load | pend_vld);
  assign conv_value  = bus.load ? bus.value     : pend_value;
  assign conv_signed = bus.load ? bus.is_signed : pend_signed;

  bcd_double_dabble #(
    .DATA_W (DATA_W),
    .NDIG   (NDIG)
  ) u_dd (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .value     (conv_value),
    .is_signed (conv_signed),
    .ready     (dd_ready),
    .busy      (dd_busy),
    .done      (dd_done),
    .bcd       (dd_bcd),
    .sign      (dd_sign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld    <= 1'b0;
      pend_value  <= '0;
      pend_signed <= 1'b0;
    end else if (bus.load && !dd_ready) begin
      pend_vld    <= 1'b1;
      pend_value  <= bus.value;
      pend_signed <= bus.is_signed;
    end else if (start) begin
      pend_vld    <= 1'b0;
    end
  end

  // Overflow decision on the finished BCD word.
  logic [4*EXT-1:0] bcd_ext;
  logic             ovf_u, ovf_n, ovf_new;

  assign bcd_ext = (4*EXT)'(dd_bcd);

  always_comb begin
    ovf_u = 1'b0;
    ovf_n = 1'b0;
    for (int i = 0; i < EXT; i++) begin
      if (i >= DIGITS && bcd_ext[4*i +: 4] != 4'd0)
        ovf_u = 1'b1;
      // A negative number gives up its top digit to the minus sign.
      if (i >= DIGITS - 1 && bcd_ext[4*i +: 4] != 4'd0)
        ovf_n = 1'b1;
    end
    ovf_new = dd_sign ? ovf_n : ovf_u;
  end

  // Display register, replaced as a whole on COMMIT only.
  logic [4*DIGITS-1:0] disp_bcd, disp_bcd_nxt;
  logic                disp_neg, disp_neg_nxt;
  logic                ovf_q, ovf_nxt;

  always_comb begin
    disp_bcd_nxt = disp_bcd;
    disp_neg_nxt = disp_neg;
    ovf_nxt      = ovf_q;
    if (dd_done) begin
      disp_bcd_nxt = bcd_ext[4*DIGITS-1:0];
      disp_neg_nxt = dd_sign;
      ovf_nxt      = ovf_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      disp_bcd <= disp_bcd_nxt;
      disp_neg <= disp_neg_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

  // Refresh timing.
  logic [CNT_W-1:0] rcnt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == CNT_W'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      rcnt <= rcnt + CNT_W'(1);
    end
  end

  // Segment selection for the current index. Reads the next display state so
  // a commit shows on the pins from the cycle after COMMIT.
  logic [IDX_W-1:0] msd;
  logic [3:0]       nib;
  logic [6:0]       seg_sel;

  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_bcd_nxt[4*i +: 4] != 4'd0)
        msd = IDX_W'(i);
    end
  end

  assign nib = disp_bcd_nxt[{idx, 2'b00} +: 4];

  always_comb begin
    seg_sel = SEG_BLANK;
    if (ovf_nxt) begin
      seg_sel = SEG_DASH;
    end else if (BLANK_EN != 0) begin
      // msd is 0 for an all-zero value, so digit 0 always shows.
      if (idx <= msd)
        seg_sel = digit_to_seg(nib);
      else if (disp_neg_nxt && idx == msd + IDX_W'(1))
        seg_sel = SEG_DASH;
    end else begin
      if (disp_neg_nxt && idx == IDX_W'(DIGITS - 1))
        seg_sel = SEG_DASH;
      else
        seg_sel = digit_to_seg(nib);
    end
  end

  // Pin registers: dark during reset, first slot starts on the next edge.
  logic [DIGITS-1:0] an_q;
  logic [6:0]        led_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= '1;
      led_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(DIGITS'(1) << idx);
      led_q <= seg_sel;
    end
  end

  assign bus.busy     = dd_busy;
  assign bus.overflow = ovf_q;
  assign bus.Anode    = an_q;
  assign bus.LED_out  = led_q;

endmodule
